// File: rtl/midi_stream_parser.sv
// midi_stream_parser: raw MIDI bytes -> held channel message + SysEx byte FIFO (SysEx path when MIDI_PARSER_SYSEX_EN is defined).
// Latency: midi_valid 1 cycle after the final data byte; SysEx bytes reach the FIFO one byte late via a pending register.
// Backpressure: none on rx (one byte per cycle); an unread message or a full FIFO drops new data and sets a sticky flag.
module midi_stream_parser #(
    parameter int SYSEX_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [3:0] midi_cmd,
    output logic [3:0] midi_ch,
    output logic [6:0] midi_data1,
    output logic [6:0] midi_data2,
    output logic       midi_valid,
    input  logic       midi_rd,
    output logic [7:0] sysex_data,
    output logic       sysex_valid,
    output logic       sysex_last,
    input  logic       sysex_rd,
    output logic       err_midi_ovf,
    output logic       err_sysex_ovf,
    input  logic       err_clr
);

    typedef enum logic [2:0] {IDLE, WAIT_D1, WAIT_D2, SKIP, SYSEX} state_t;

    state_t     state, state_nxt;
    logic [7:0] run_status, run_status_nxt;   // 0 means "no running status"
    logic [6:0] d1_q, d1_nxt;
    logic       emit;
    logic [6:0] emit_d1, emit_d2;

    logic is_rt, is_data, is_chan, one_data;
    assign is_rt    = (rx_data[7:3] == 5'b11111);
    assign is_data  = ~rx_data[7];
    assign is_chan  = rx_data[7] && (rx_data[6:4] != 3'b111);
    assign one_data = (run_status[7:4] == 4'hC) || (run_status[7:4] == 4'hD);

`ifdef MIDI_PARSER_SYSEX_EN
    logic       pend_vld, pend_vld_nxt;
    logic [6:0] pend_dat, pend_dat_nxt;
    logic       sx_push, sx_push_last;
    logic [6:0] sx_push_dat;
`endif

    // Parser state register (running status, first data byte, SysEx pending byte)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            run_status <= '0;
            d1_q       <= '0;
`ifdef MIDI_PARSER_SYSEX_EN
            pend_vld   <= 1'b0;
            pend_dat   <= '0;
`endif
        end else begin
            state      <= state_nxt;
            run_status <= run_status_nxt;
            d1_q       <= d1_nxt;
`ifdef MIDI_PARSER_SYSEX_EN
            pend_vld   <= pend_vld_nxt;
            pend_dat   <= pend_dat_nxt;
`endif
        end
    end

    // Byte classification, next state, message emission and SysEx push decode
    always_comb begin
        state_nxt      = state;
        run_status_nxt = run_status;
        d1_nxt         = d1_q;
        emit           = 1'b0;
        emit_d1        = d1_q;
        emit_d2        = '0;
`ifdef MIDI_PARSER_SYSEX_EN
        sx_push        = 1'b0;
        sx_push_last   = 1'b0;
        sx_push_dat    = pend_dat;
        pend_vld_nxt   = pend_vld;
        pend_dat_nxt   = pend_dat;
`endif
        // Real-time bytes are invisible to the parser
        if (rx_valid && !is_rt) begin
            if (is_data) begin
                case (state)
                    WAIT_D1: begin
                        if (one_data) begin
                            emit    = 1'b1;
                            emit_d1 = rx_data[6:0];
                        end else begin
                            d1_nxt    = rx_data[6:0];
                            state_nxt = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        emit      = 1'b1;
                        emit_d2   = rx_data[6:0];
                        state_nxt = WAIT_D1;
                    end
`ifdef MIDI_PARSER_SYSEX_EN
                    SYSEX: begin
                        // Previous byte is now known not to be the last one
                        sx_push      = pend_vld;
                        pend_vld_nxt = 1'b1;
                        pend_dat_nxt = rx_data[6:0];
                    end
`endif
                    default: ;
                endcase
            end else begin
`ifdef MIDI_PARSER_SYSEX_EN
                // Any status byte closes an open SysEx, flushing the pending byte as last
                sx_push      = (state == SYSEX) && pend_vld;
                sx_push_last = 1'b1;
                pend_vld_nxt = 1'b0;
`endif
                if (is_chan) begin
                    run_status_nxt = rx_data;
                    state_nxt      = WAIT_D1;
                end else begin
                    run_status_nxt = '0;
                    if (rx_data == 8'hF7)
                        state_nxt = IDLE;
`ifdef MIDI_PARSER_SYSEX_EN
                    else if (rx_data == 8'hF0)
                        state_nxt = SYSEX;
`endif
                    else
                        state_nxt = SKIP;
                end
            end
        end
    end

    // Held message register with drop-on-full and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            midi_valid   <= 1'b0;
            midi_cmd     <= '0;
            midi_ch      <= '0;
            midi_data1   <= '0;
            midi_data2   <= '0;
            err_midi_ovf <= 1'b0;
        end else begin
            if (emit && (!midi_valid || midi_rd)) begin
                midi_valid <= 1'b1;
                midi_cmd   <= run_status[7:4];
                midi_ch    <= run_status[3:0];
                midi_data1 <= emit_d1;
                midi_data2 <= emit_d2;
            end else if (midi_rd) begin
                midi_valid <= 1'b0;
            end
            if (err_clr)
                err_midi_ovf <= 1'b0;
            else if (emit && midi_valid && !midi_rd)
                err_midi_ovf <= 1'b1;
        end
    end

`ifdef MIDI_PARSER_SYSEX_EN
    localparam int AW = $clog2(SYSEX_DEPTH);

    logic [7:0]    fifo_mem [SYSEX_DEPTH];    // {last, data[6:0]}
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          fifo_full, fifo_pop, fifo_push;

    assign fifo_full = (fifo_cnt == (AW+1)'(SYSEX_DEPTH));
    assign fifo_pop  = sysex_rd && (fifo_cnt != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign fifo_push = sx_push && (!fifo_full || fifo_pop);

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (fifo_push)
            fifo_mem[wr_ptr] <= {sx_push_last, sx_push_dat};
    end

    // FIFO pointers, occupancy and overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            err_sysex_ovf <= 1'b0;
        end else begin
            if (fifo_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + (AW+1)'(fifo_push) - (AW+1)'(fifo_pop);
            if (err_clr)
                err_sysex_ovf <= 1'b0;
            else if (sx_push && !fifo_push)
                err_sysex_ovf <= 1'b1;
        end
    end

    assign sysex_valid = (fifo_cnt != '0);
    assign sysex_data  = sysex_valid ? {1'b0, fifo_mem[rd_ptr][6:0]} : 8'h00;
    assign sysex_last  = sysex_valid & fifo_mem[rd_ptr][7];
`else
    logic unused_sysex;
    assign unused_sysex  = sysex_rd | (SYSEX_DEPTH < 2);
    assign sysex_valid   = 1'b0;
    assign sysex_last    = 1'b0;
    assign sysex_data    = 8'h00;
    assign err_sysex_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_midi_stream_parser.sv
// tb_midi_stream_parser: self-checking bench for midi_stream_parser.
// Directed vector table, hand-written SysEx/reset sequences, then randomized bytes against a queue-based model.
// Inputs driven at the falling edge and held across the rising edge; outputs sampled at the falling edge.
module tb_midi_stream_parser;

    localparam int DEPTH = 16;
`ifdef MIDI_PARSER_SYSEX_EN
    localparam bit SYSEX_ON = 1'b1;
`else
    localparam bit SYSEX_ON = 1'b0;
`endif

    logic       clk, rst_n;
    logic [7:0] rx_data;
    logic       rx_valid, midi_rd, sysex_rd, err_clr;
    logic [3:0] midi_cmd, midi_ch;
    logic [6:0] midi_data1, midi_data2;
    logic       midi_valid, sysex_valid, sysex_last, err_midi_ovf, err_sysex_ovf;
    logic [7:0] sysex_data;

    midi_stream_parser #(.SYSEX_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .midi_cmd(midi_cmd), .midi_ch(midi_ch), .midi_data1(midi_data1), .midi_data2(midi_data2),
        .midi_valid(midi_valid), .midi_rd(midi_rd),
        .sysex_data(sysex_data), .sysex_valid(sysex_valid), .sysex_last(sysex_last), .sysex_rd(sysex_rd),
        .err_midi_ovf(err_midi_ovf), .err_sysex_ovf(err_sysex_ovf), .err_clr(err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus: applied at a falling edge, held over the rising edge
    task automatic drive(input logic iv, input logic [7:0] b, input logic mrd, input logic srd, input logic clr);
        rx_valid = iv; rx_data = b; midi_rd = mrd; sysex_rd = srd; err_clr = clr;
        @(negedge clk);
        rx_valid = 1'b0; midi_rd = 1'b0; sysex_rd = 1'b0; err_clr = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [22:0] msg_vec();
        return {midi_valid, midi_cmd, midi_ch, midi_data1, midi_data2};
    endfunction

    function automatic logic [10:0] sx_vec();
        return {sysex_valid, sysex_last, sysex_data, err_sysex_ovf};
    endfunction

    task automatic pop_check(input string name, input logic [6:0] dat, input logic last);
        check(name, {sysex_valid, sysex_last, sysex_data}, {1'b1, last, 1'b0, dat});
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    // ---------------- behavioural reference model ----------------
    localparam int MODE_DISCARD = 0, MODE_CHAN = 1, MODE_SYSEX = 2;
    int         m_mode;
    logic [7:0] m_rs;
    logic [6:0] m_dq[$];        // data bytes collected for the current message
    logic       m_pend_v;
    logic [6:0] m_pend;
    logic [7:0] m_sq[$];        // SysEx FIFO contents {last, data}
    logic       m_mv, m_movf, m_sovf;
    logic [3:0] m_cmd, m_ch;
    logic [6:0] m_d1, m_d2;

    task automatic model_reset();
        m_mode = MODE_DISCARD; m_rs = 8'h00; m_dq.delete(); m_pend_v = 1'b0; m_pend = '0;
        m_sq.delete(); m_mv = 1'b0; m_movf = 1'b0; m_sovf = 1'b0;
        m_cmd = '0; m_ch = '0; m_d1 = '0; m_d2 = '0;
    endtask

    task automatic model_step(input logic iv, input logic [7:0] b, input logic mrd, input logic srd, input logic clr);
        bit         emit = 0, spush = 0, mset = 0, sset = 0, full;
        logic [6:0] e1 = '0, e2 = '0;
        logic [7:0] sdat = '0;
        int         need;
        if (iv && b < 8'hF8) begin
            if (!b[7]) begin
                if (m_mode == MODE_CHAN) begin
                    m_dq.push_back(b[6:0]);
                    need = (m_rs[7:4] == 4'hC || m_rs[7:4] == 4'hD) ? 1 : 2;
                    if (m_dq.size() == need) begin
                        emit = 1; e1 = m_dq[0]; e2 = (need == 2) ? m_dq[1] : 7'h00;
                        m_dq.delete();
                    end
                end else if (m_mode == MODE_SYSEX) begin
                    if (m_pend_v) begin spush = 1; sdat = {1'b0, m_pend}; end
                    m_pend_v = 1'b1; m_pend = b[6:0];
                end
            end else begin
                if (m_mode == MODE_SYSEX && m_pend_v) begin spush = 1; sdat = {1'b1, m_pend}; end
                m_pend_v = 1'b0;
                m_dq.delete();
                if (b < 8'hF0) begin
                    m_rs = b; m_mode = MODE_CHAN;
                end else begin
                    m_rs = 8'h00;
                    m_mode = (b == 8'hF0 && SYSEX_ON) ? MODE_SYSEX : MODE_DISCARD;
                end
            end
        end
        if (emit) begin
            if (!m_mv || mrd) begin
                m_mv = 1'b1; m_cmd = m_rs[7:4]; m_ch = m_rs[3:0]; m_d1 = e1; m_d2 = e2;
            end else mset = 1;
        end else if (mrd) m_mv = 1'b0;
        full = (m_sq.size() == DEPTH);
        if (srd && m_sq.size() > 0) begin
            void'(m_sq.pop_front());
            full = 0;
        end
        if (spush) begin
            if (!full) m_sq.push_back(sdat);
            else sset = 1;
        end
        m_movf = clr ? 1'b0 : (m_movf | mset);
        m_sovf = clr ? 1'b0 : (m_sovf | sset);
    endtask

    task automatic model_compare(input int cyc);
        logic [10:0] exp_sx;
        if (m_sq.size() > 0) exp_sx = {1'b1, m_sq[0][7], 1'b0, m_sq[0][6:0], m_sovf};
        else                 exp_sx = {2'b00, 8'h00, m_sovf};
        check($sformatf("rand_msg@%0d", cyc), msg_vec(), {m_mv, m_cmd, m_ch, m_d1, m_d2});
        check($sformatf("rand_movf@%0d", cyc), err_midi_ovf, m_movf);
        check($sformatf("rand_sysex@%0d", cyc), sx_vec(), exp_sx);
    endtask

    function automatic logic [7:0] rand_byte();
        int         r = $urandom_range(99);
        logic [7:0] b = 8'($urandom);
        if (r < 55)      return {1'b0, b[6:0]};
        else if (r < 72) return {1'b1, (b[6:4] == 3'b111) ? 3'b000 : b[6:4], b[3:0]};
        else if (r < 80) return {5'b11111, b[2:0]};
        else if (r < 86) return 8'hF1 + 8'(b[2:0] % 3'd6);
        else if (r < 93) return 8'hF0;
        else             return 8'hF7;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic       iv;
        logic [7:0] dat;
        logic       rd;
        logic       clr;
        logic       ev;
        logic [3:0] ec;
        logic [3:0] ech;
        logic [6:0] e1;
        logic [6:0] e2;
        logic       eovf;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic iv, input logic [7:0] dat, input logic rd, input logic clr,
                           input logic ev, input logic [3:0] ec, input logic [3:0] ech,
                           input logic [6:0] e1, input logic [6:0] e2, input logic eovf);
        vec_t v;
        v.iv = iv; v.dat = dat; v.rd = rd; v.clr = clr; v.ev = ev;
        v.ec = ec; v.ech = ech; v.e1 = e1; v.e2 = e2; v.eovf = eovf;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; midi_rd = 1'b0; sysex_rd = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        //        iv    dat    rd clr  ev cmd  ch  d1     d2     ovf
        add_vec(1, 8'h93, 0, 0, 0, 4'h0, 4'h0, 7'h00, 7'h00, 0);
        add_vec(1, 8'h3C, 0, 0, 0, 4'h0, 4'h0, 7'h00, 7'h00, 0);
        add_vec(1, 8'h64, 0, 0, 1, 4'h9, 4'h3, 7'h3C, 7'h64, 0);
        add_vec(1, 8'h40, 1, 0, 0, 4'h9, 4'h3, 7'h3C, 7'h64, 0);
        add_vec(1, 8'h00, 0, 0, 1, 4'h9, 4'h3, 7'h40, 7'h00, 0);
        add_vec(0, 8'h00, 1, 0, 0, 4'h9, 4'h3, 7'h40, 7'h00, 0);
        add_vec(1, 8'hC5, 0, 0, 0, 4'h9, 4'h3, 7'h40, 7'h00, 0);
        add_vec(1, 8'h0A, 0, 0, 1, 4'hC, 4'h5, 7'h0A, 7'h00, 0);
        add_vec(1, 8'hF8, 1, 0, 0, 4'hC, 4'h5, 7'h0A, 7'h00, 0);
        add_vec(1, 8'h0B, 0, 0, 1, 4'hC, 4'h5, 7'h0B, 7'h00, 0);
        add_vec(0, 8'h00, 1, 0, 0, 4'hC, 4'h5, 7'h0B, 7'h00, 0);
        add_vec(1, 8'hB0, 0, 0, 0, 4'hC, 4'h5, 7'h0B, 7'h00, 0);
        add_vec(1, 8'h07, 0, 0, 0, 4'hC, 4'h5, 7'h0B, 7'h00, 0);
        add_vec(1, 8'h10, 0, 0, 1, 4'hB, 4'h0, 7'h07, 7'h10, 0);
        add_vec(1, 8'hB0, 0, 0, 1, 4'hB, 4'h0, 7'h07, 7'h10, 0);
        add_vec(1, 8'h08, 0, 0, 1, 4'hB, 4'h0, 7'h07, 7'h10, 0);
        add_vec(1, 8'h20, 0, 0, 1, 4'hB, 4'h0, 7'h07, 7'h10, 1);
        add_vec(0, 8'h00, 0, 1, 1, 4'hB, 4'h0, 7'h07, 7'h10, 0);
        add_vec(0, 8'h00, 1, 0, 0, 4'hB, 4'h0, 7'h07, 7'h10, 0);
        add_vec(1, 8'h01, 0, 0, 0, 4'hB, 4'h0, 7'h07, 7'h10, 0);
        add_vec(1, 8'h02, 0, 0, 1, 4'hB, 4'h0, 7'h01, 7'h02, 0);
        add_vec(1, 8'h03, 0, 0, 1, 4'hB, 4'h0, 7'h01, 7'h02, 0);
        add_vec(1, 8'h04, 0, 1, 1, 4'hB, 4'h0, 7'h01, 7'h02, 0);
        add_vec(1, 8'hF2, 1, 0, 0, 4'hB, 4'h0, 7'h01, 7'h02, 0);
        add_vec(1, 8'h11, 0, 0, 0, 4'hB, 4'h0, 7'h01, 7'h02, 0);
        add_vec(1, 8'h22, 0, 0, 0, 4'hB, 4'h0, 7'h01, 7'h02, 0);
        add_vec(1, 8'h90, 0, 0, 0, 4'hB, 4'h0, 7'h01, 7'h02, 0);
        add_vec(1, 8'h30, 0, 0, 0, 4'hB, 4'h0, 7'h01, 7'h02, 0);
        add_vec(1, 8'h40, 0, 0, 1, 4'h9, 4'h0, 7'h30, 7'h40, 0);
        add_vec(1, 8'h31, 0, 0, 1, 4'h9, 4'h0, 7'h30, 7'h40, 0);
        add_vec(1, 8'h41, 1, 0, 1, 4'h9, 4'h0, 7'h31, 7'h41, 0);
        add_vec(0, 8'h00, 1, 0, 0, 4'h9, 4'h0, 7'h31, 7'h41, 0);
        add_vec(1, 8'hF0, 0, 0, 0, 4'h9, 4'h0, 7'h31, 7'h41, 0);
        add_vec(1, 8'h12, 0, 0, 0, 4'h9, 4'h0, 7'h31, 7'h41, 0);
        add_vec(1, 8'h13, 0, 0, 0, 4'h9, 4'h0, 7'h31, 7'h41, 0);
        add_vec(1, 8'hF7, 0, 0, 0, 4'h9, 4'h0, 7'h31, 7'h41, 0);

        do_reset();
        check("reset_msg", {msg_vec(), err_midi_ovf}, 24'h0);
        check("reset_sysex", sx_vec(), 11'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].dat, vecs[i].rd, 1'b0, vecs[i].clr);
            check($sformatf("vec%0d_msg", i), msg_vec(),
                  {vecs[i].ev, vecs[i].ec, vecs[i].ech, vecs[i].e1, vecs[i].e2});
            check($sformatf("vec%0d_ovf", i), err_midi_ovf, vecs[i].eovf);
        end

`ifdef MIDI_PARSER_SYSEX_EN
        // The table's trailing F0,12,13,F7 leaves two bytes queued
        pop_check("tbl_sx0", 7'h12, 1'b0);
        pop_check("tbl_sx1", 7'h13, 1'b1);
        check("tbl_sx_empty", sysex_valid, 1'b0);

        do_reset();
        send(8'hF0); send(8'h7E);
        check("sx_pending", sysex_valid, 1'b0);
        send(8'h01);
        check("sx_first_push", {sysex_valid, sysex_last, sysex_data}, {2'b10, 8'h7E});
        send(8'h02); send(8'hF7);
        pop_check("sx_b0", 7'h7E, 1'b0);
        pop_check("sx_b1", 7'h01, 1'b0);
        pop_check("sx_b2", 7'h02, 1'b1);
        check("sx_empty", sysex_valid, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("sx_pop_empty", sx_vec(), 11'h0);

        send(8'hF0); send(8'hF7);
        check("sx_f0f7_nothing", sysex_valid, 1'b0);

        send(8'hF0); send(8'h11); send(8'h90); send(8'h30); send(8'h40);
        pop_check("sx_term_by_status", 7'h11, 1'b1);
        check("sx_then_msg", msg_vec(), {1'b1, 4'h9, 4'h0, 7'h30, 7'h40});
        check("sx_then_empty", sysex_valid, 1'b0);

        do_reset();
        send(8'h80); send(8'h10); send(8'h20);
        send(8'hF0);
        for (int i = 0; i < DEPTH + 2; i++) send(8'(i + 1));
        check("sx_ovf_flag", err_sysex_ovf, 1'b1);
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("sx_full%0d", i), 7'(i + 1), 1'b0);
        check("sx_full_drained", sysex_valid, 1'b0);
        send(8'h55); send(8'h56);
        check("sx_refill", {sysex_valid, sysex_data}, {1'b1, 8'd18});
        #2 rst_n = 1'b0;
        #1;
        check("arst_msg", {msg_vec(), err_midi_ovf}, 24'h0);
        check("arst_sysex", sx_vec(), 11'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        send(8'h30); send(8'h40); send(8'hF7);
        check("post_rst_msg", midi_valid, 1'b0);
        check("post_rst_sysex", sysex_valid, 1'b0);
`else
        // Without the SysEx path, F0 leads to discard and the SysEx outputs stay quiet
        check("nosx_outputs", sx_vec(), 11'h0);
        do_reset();
        send(8'h90); send(8'h30); send(8'h40);
        drive(1'b1, 8'hF0, 1'b1, 1'b0, 1'b0);
        send(8'h31);
        drive(1'b1, 8'h41, 1'b0, 1'b1, 1'b0);
        send(8'h32);
        check("nosx_discard", midi_valid, 1'b0);
        check("nosx_sysex", sx_vec(), 11'h0);
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic       iv, mrd, srd, clr;
            logic [7:0] b;
            model_compare(c);
            iv  = ($urandom_range(99) < 80);
            b   = rand_byte();
            mrd = ($urandom_range(99) < 40);
            srd = ($urandom_range(99) < 30);
            clr = ($urandom_range(99) < 3);
            model_step(iv, b, mrd, srd, clr);
            drive(iv, b, mrd, srd, clr);
        end
        model_compare(3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
